// File: rtl/blit_ctrl.sv
// blit_ctrl: blitter sequencer for the blit requester port of the VRAM arbiter.
// Performs rectangular VRAM copy (read then write) or constant fill, one 16-bit
// word per access, with signed per-line source/destination modulo.
//
// Ports:
//   clk, reset_i           clock, asynchronous active-high reset
//   blit_reg_wr_i/num/data XR blit register write (write WORDS to start)
//   blit_vram_sel_o        VRAM request; blit_vram_ack_i grant pulse
//   blit_wr_o, blit_wr_mask_o, blit_addr_o, blit_data_o  access attributes
//   vram_data_i            read data, valid the cycle after a read ack
//   busy_o, done_o         operation in progress, 1-cycle completion pulse
module blit_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              blit_reg_wr_i,
  input  logic [3:0]        blit_reg_num_i,
  input  logic [15:0]       blit_reg_data_i,
  output logic              blit_vram_sel_o,
  input  logic              blit_vram_ack_i,
  output logic              blit_wr_o,
  output logic [3:0]        blit_wr_mask_o,
  output logic [ADDR_W-1:0] blit_addr_o,
  output logic [15:0]       blit_data_o,
  input  logic [15:0]       vram_data_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_REQ} state_t;

  state_t state, state_nxt;

  // configuration registers
  logic [15:0] src_cfg, mod_s, dst_cfg, mod_d, lines_cfg;
  logic        const_mode;
  logic [3:0]  wr_mask;

  // working registers
  logic [ADDR_W-1:0] src_w, dst_w;
  logic [CNT_W-1:0]  word_cnt, line_cnt, words_rld;
  logic [15:0]       data_q;
  logic              done_q;

  logic              cfg_wr, start, wr_ack, last_word, last_line, complete;
  logic [ADDR_W-1:0] mod_s_ext, mod_d_ext;

  // Registers only accept writes while idle; this also drops a WORDS write
  // that coincides with the completing ack.
  assign cfg_wr    = blit_reg_wr_i && (state == IDLE);
  assign start     = cfg_wr && (blit_reg_num_i == 4'd6);
  assign wr_ack    = (state == WR_REQ) && blit_vram_ack_i;
  assign last_word = (word_cnt == '0);
  assign last_line = (line_cnt == '0);
  assign complete  = wr_ack && last_word && last_line;
  assign mod_s_ext = ADDR_W'($signed(mod_s));
  assign mod_d_ext = ADDR_W'($signed(mod_d));

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    blit_vram_sel_o = 1'b0;
    blit_wr_o       = 1'b0;
    blit_wr_mask_o  = 4'hF;
    blit_addr_o     = '0;
    blit_data_o     = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = const_mode ? WR_REQ : RD_REQ;
      end
      RD_REQ: begin
        blit_vram_sel_o = 1'b1;
        blit_addr_o     = src_w;
        if (blit_vram_ack_i) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        state_nxt = WR_REQ;
      end
      WR_REQ: begin
        blit_vram_sel_o = 1'b1;
        blit_wr_o       = 1'b1;
        blit_wr_mask_o  = wr_mask;
        blit_addr_o     = dst_w;
        blit_data_o     = const_mode ? src_cfg : data_q;
        if (blit_vram_ack_i) begin
          if (complete)        state_nxt = IDLE;
          else if (const_mode) state_nxt = WR_REQ;
          else                 state_nxt = RD_REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      src_cfg    <= '0;
      mod_s      <= '0;
      dst_cfg    <= '0;
      mod_d      <= '0;
      lines_cfg  <= '0;
      const_mode <= 1'b0;
      wr_mask    <= 4'hF;
      src_w      <= '0;
      dst_w      <= '0;
      word_cnt   <= '0;
      line_cnt   <= '0;
      words_rld  <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= complete;
      if (cfg_wr) begin
        case (blit_reg_num_i)
          4'd0: src_cfg   <= blit_reg_data_i;
          4'd1: mod_s     <= blit_reg_data_i;
          4'd2: dst_cfg   <= blit_reg_data_i;
          4'd3: mod_d     <= blit_reg_data_i;
          4'd4: lines_cfg <= blit_reg_data_i;
          4'd5: begin
            const_mode <= blit_reg_data_i[0];
            wr_mask    <= blit_reg_data_i[7:4];
          end
          4'd6: begin
            word_cnt  <= CNT_W'(blit_reg_data_i);
            words_rld <= CNT_W'(blit_reg_data_i);
            line_cnt  <= CNT_W'(lines_cfg);
            src_w     <= ADDR_W'(src_cfg);
            dst_w     <= ADDR_W'(dst_cfg);
          end
          default: ;
        endcase
      end
      if (state == RD_DATA) data_q <= vram_data_i;
      if (wr_ack && !complete) begin
        if (last_word) begin
          if (!const_mode) src_w <= src_w + ADDR_W'(1) + mod_s_ext;
          dst_w    <= dst_w + ADDR_W'(1) + mod_d_ext;
          word_cnt <= words_rld;
          line_cnt <= line_cnt - CNT_W'(1);
        end else begin
          if (!const_mode) src_w <= src_w + ADDR_W'(1);
          dst_w    <= dst_w + ADDR_W'(1);
          word_cnt <= word_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_blit_ctrl.sv
// tb_blit_ctrl: scoreboard bench for blit_ctrl. Expected reads/writes are
// queued when an operation is started and popped as the arbiter model grants.
module tb_blit_ctrl;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        blit_reg_wr_i = 1'b0;
  logic [3:0]  blit_reg_num_i = '0;
  logic [15:0] blit_reg_data_i = '0;
  logic        blit_vram_sel_o;
  logic        blit_vram_ack_i = 1'b0;
  logic        blit_wr_o;
  logic [3:0]  blit_wr_mask_o;
  logic [15:0] blit_addr_o;
  logic [15:0] blit_data_o;
  logic [15:0] vram_data_i = 16'hDEAD;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  blit_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .blit_reg_wr_i   (blit_reg_wr_i),
    .blit_reg_num_i  (blit_reg_num_i),
    .blit_reg_data_i (blit_reg_data_i),
    .blit_vram_sel_o (blit_vram_sel_o),
    .blit_vram_ack_i (blit_vram_ack_i),
    .blit_wr_o       (blit_wr_o),
    .blit_wr_mask_o  (blit_wr_mask_o),
    .blit_addr_o     (blit_addr_o),
    .blit_data_o     (blit_data_o),
    .vram_data_i     (vram_data_i),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  mask;
  } wr_t;

  wr_t         wr_q[$];
  logic [15:0] rd_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // arbiter / VRAM model, acting on the falling edge
  int          delay = 0;
  bit          spur = 1'b0;
  int          wait_cnt = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  int          first_wr = 0;
  int          last_wr = 0;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_val = '0;
  logic        p_sel = 1'b0, p_ack = 1'b0, p_wr = 1'b0;
  logic [15:0] p_addr = '0, p_data = '0;
  wr_t         e_w;

  always @(negedge clk) begin
    cyc++;
    if (reset_i) begin
      blit_vram_ack_i = 1'b0;
      vram_data_i     = 16'hDEAD;
      wait_cnt        = 0;
      rd_pend         = 1'b0;
      p_sel           = 1'b0;
      p_ack           = 1'b0;
    end else begin
      vram_data_i = rd_pend ? rd_val : 16'hDEAD;
      rd_pend     = 1'b0;
      if (done_o) begin
        done_cnt++;
        check("done_busy", {31'd0, busy_o}, 32'd0);
        check("done_sel", {31'd0, blit_vram_sel_o}, 32'd0);
      end
      if (p_sel && !p_ack && blit_vram_sel_o) begin
        check("hold_addr", {16'd0, blit_addr_o}, {16'd0, p_addr});
        check("hold_data", {16'd0, blit_data_o}, {16'd0, p_data});
        check("hold_wr", {31'd0, blit_wr_o}, {31'd0, p_wr});
      end
      if (blit_vram_sel_o) begin
        if (wait_cnt >= delay) begin
          blit_vram_ack_i = 1'b1;
          wait_cnt = 0;
          if (blit_wr_o) begin
            wr_cnt++;
            if (wr_cnt == 1) first_wr = cyc;
            last_wr = cyc;
            if (wr_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
            else begin
              e_w = wr_q.pop_front();
              check("wr_addr", {16'd0, blit_addr_o}, {16'd0, e_w.addr});
              check("wr_data", {16'd0, blit_data_o}, {16'd0, e_w.data});
              check("wr_mask", {28'd0, blit_wr_mask_o}, {28'd0, e_w.mask});
            end
          end else begin
            if (rd_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
            else check("rd_addr", {16'd0, blit_addr_o}, {16'd0, rd_q.pop_front()});
            rd_pend = 1'b1;
            rd_val  = blit_addr_o ^ 16'hFFFF;
          end
        end else begin
          blit_vram_ack_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        blit_vram_ack_i = spur;
        wait_cnt = 0;
      end
      p_sel  = blit_vram_sel_o;
      p_ack  = blit_vram_ack_i;
      p_wr   = blit_wr_o;
      p_addr = blit_addr_o;
      p_data = blit_data_o;
    end
  end

  // shadow of what the bench believes the config registers hold
  logic [15:0] c_src = '0, c_mods = '0, c_dst = '0, c_modd = '0, c_lines = '0, c_ctrl = 16'h00F0;
  bit          exp_const;
  int          exp_n;
  int          d0;

  task automatic reg_wr(input logic [3:0] n, input logic [15:0] d);
    @(negedge clk);
    blit_reg_wr_i   = 1'b1;
    blit_reg_num_i  = n;
    blit_reg_data_i = d;
    @(negedge clk);
    blit_reg_wr_i   = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] src, input logic [15:0] mods, input logic [15:0] dst,
                     input logic [15:0] modd, input logic [15:0] lines, input logic [15:0] ctrl);
    c_src = src; c_mods = mods; c_dst = dst; c_modd = modd; c_lines = lines; c_ctrl = ctrl;
    reg_wr(4'd0, src);
    reg_wr(4'd1, mods);
    reg_wr(4'd2, dst);
    reg_wr(4'd3, modd);
    reg_wr(4'd4, lines);
    reg_wr(4'd5, ctrl);
  endtask

  task automatic start(input logic [15:0] words);
    logic [15:0] s, d;
    wr_t e;
    s = c_src;
    d = c_dst;
    exp_const = c_ctrl[0];
    exp_n = 0;
    for (int unsigned l = 0; l <= c_lines; l++) begin
      for (int unsigned w = 0; w <= words; w++) begin
        e.addr = d;
        e.data = exp_const ? c_src : (s ^ 16'hFFFF);
        e.mask = c_ctrl[7:4];
        if (!exp_const) rd_q.push_back(s);
        wr_q.push_back(e);
        exp_n++;
        if (w == words) begin
          if (!exp_const) s = s + 16'd1 + c_mods;
          d = d + 16'd1 + c_modd;
        end else begin
          if (!exp_const) s = s + 16'd1;
          d = d + 16'd1;
        end
      end
    end
    d0 = done_cnt;
    wr_cnt = 0;
    reg_wr(4'd6, words);
    check("start_busy", {31'd0, busy_o}, 32'd1);
    check("start_sel", {31'd0, blit_vram_sel_o}, 32'd1);
  endtask

  task automatic finish_op(input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, {31'd0, (n >= 3000)}, 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt - d0, 32'd1);
    check({tag, "_wr_cnt"}, wr_cnt, exp_n);
    check({tag, "_wr_left"}, wr_q.size(), 32'd0);
    check({tag, "_rd_left"}, rd_q.size(), 32'd0);
    check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    if (delay == 0)
      check({tag, "_span"}, last_wr - first_wr, exp_const ? exp_n - 1 : 3 * (exp_n - 1));
    wr_q.delete();
    rd_q.delete();
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_sel", {31'd0, blit_vram_sel_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_wr", {31'd0, blit_wr_o}, 32'd0);
    check("rst_mask", {28'd0, blit_wr_mask_o}, 32'hF);
    check("rst_addr", {16'd0, blit_addr_o}, 32'd0);
    check("rst_data", {16'd0, blit_data_o}, 32'd0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // constant fill, two lines with destination modulo
    delay = 0;
    cfg(16'hA5A5, 16'h0000, 16'h1000, 16'h0004, 16'h0001, 16'h00F1);
    start(16'd3);
    finish_op("fill");

    // copy, one line
    cfg(16'h0200, 16'h0000, 16'h3000, 16'h0004, 16'h0000, 16'h00F0);
    start(16'd2);
    finish_op("copy");

    // same copy and fill with slow arbiter and spurious acks while idle
    delay = 5;
    spur  = 1'b1;
    start(16'd2);
    finish_op("copy_slow");
    cfg(16'hA5A5, 16'h0000, 16'h1000, 16'h0004, 16'h0001, 16'h00F1);
    start(16'd3);
    finish_op("fill_slow");
    spur  = 1'b0;
    delay = 0;

    // address wrap with negative destination modulo
    cfg(16'h1234, 16'h0000, 16'hFFFE, 16'hFFFD, 16'h0001, 16'h0031);
    start(16'd2);
    finish_op("wrap");

    // minimal single-word copy
    cfg(16'h0010, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 16'h0050);
    start(16'd0);
    finish_op("single");

    // register writes while busy are ignored
    delay = 2;
    cfg(16'h0400, 16'hFFFF, 16'h2000, 16'h0002, 16'h0001, 16'h0030);
    start(16'd3);
    reg_wr(4'd2, 16'h5555);
    reg_wr(4'd6, 16'd7);
    finish_op("lockout");
    delay = 0;
    start(16'd0);
    finish_op("lockout_dst");

    // asynchronous reset during the second word
    cfg(16'h7777, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h00F1);
    start(16'd7);
    n = 0;
    while (wr_cnt < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach", {31'd0, (n >= 100)}, 32'd0);
    check("pre_rst_sel", {31'd0, blit_vram_sel_o}, 32'd1);
    d0 = done_cnt;
    #2 reset_i = 1'b1;
    #1;
    check("arst_sel", {31'd0, blit_vram_sel_o}, 32'd0);
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_done", {31'd0, done_o}, 32'd0);
    wr_q.delete();
    rd_q.delete();
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_done", done_cnt - d0, 32'd0);
    check("post_rst_sel", {31'd0, blit_vram_sel_o}, 32'd0);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);
    check("post_rst_mask", {28'd0, blit_wr_mask_o}, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
